coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
Front-end interface between the physical coin mechanism and the coin-summing logic. It produces the 3-bit coin codes that the summer and vending FSM consume. Inputs are six raw, asynchronous, one-line-per-denomination sensor signals. The block synchronises, debounces and validates each coin pulse, then presents one coin code per accepted coin on a valid/ready handshake. Invalid, disabled or jammed coins are diverted to the return chute via reject_gate.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a single sensor pattern must be stable before the coin counts as real
MAX_PULSE_CYCLES, 4096, cycles a sensor may stay asserted before the block declares a jam
COOLDOWN_CYCLES, 64, dead time after each coin or reject during which the sensors are ignored
CNT_W, 13, counter width; must hold max(MAX_PULSE_CYCLES, COOLDOWN_CYCLES)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
accept_enable  in  1  FSM permits coin intake (low while dispensing food or change)
coin_sense  in  6  raw async sensor lines; bit0=1c, bit1=5c, bit2=10c, bit3=25c, bit4=50c, bit5=100c
coin_ready  in  1  consumer accepts the presented coin_code this cycle
coin_code  out  3  accepted coin: 001=1c, 010=5c, 011=10c, 100=25c, 101=50c, 110=100c; 000=none
coin_valid  out  1  coin_code is valid; held until coin_ready
reject_gate  out  1  drives the return-chute flap
jam_error  out  1  sensor stuck asserted
busy  out  1  FSM not in IDLE
reject_count  out  8  saturating count of rejected coins

Behaviour:
- Reset (reset=0, async): FSM enters IDLE, all counters clear, every output is 0.
- Synchroniser: coin_sense passes through 2 flops to give sense_s. All decisions use sense_s only.
- All outputs are registered and decoded from the state and latched registers.
- IDLE:
  - sense_s==0: stay in IDLE.
  - sense_s not one-hot, or accept_enable=0: go to REJECT.
  - Otherwise: latch the pattern, set cnt=1, go to MEASURE.
- MEASURE:
  - sense_s==latched: increment cnt. When cnt==DEBOUNCE_CYCLES, go to WAIT_RELEASE with cnt kept running.
  - sense_s==0 before that point: treat as a glitch and return to IDLE. No output, no reject.
  - Any other pattern: go to REJECT.
- WAIT_RELEASE:
  - sense_s==0: go to PRESENT.
  - A different nonzero pattern: go to REJECT.
  - cnt reaching MAX_PULSE_CYCLES: go to JAM.
- PRESENT:
  - coin_valid=1 and coin_code=encode(latched). Both stay stable until coin_ready=1 is sampled, then go to COOLDOWN.
  - coin_valid drops on the next edge after the handshake.
  - Changes on accept_enable are ignored here; the coin is already in.
- REJECT:
  - reject_gate=1 and reject_count increments once on entry, saturating at 255.
  - sense_s==0: go to COOLDOWN.
  - cnt reaching MAX_PULSE_CYCLES: go to JAM.
- JAM:
  - jam_error=1 and reject_gate=1.
  - Leave to COOLDOWN only once sense_s==0; jam_error then clears.
- COOLDOWN:
  - Outputs idle and sense_s is ignored for COOLDOWN_CYCLES, then go to IDLE.
  - A sensor still asserted at that point is evaluated as a new coin.
- busy=1 in every state except IDLE.
- Latency: let N be the first edge at which the raw release is sampled. sense_s shows 0 after edge N+1, and coin_valid is high after edge N+2.
- Simultaneous events:
  - In IDLE, a multi-bit pattern always rejects, even with accept_enable=1.
  - In PRESENT, coin_ready arriving in the same cycle that coin_valid rises completes the transfer in one cycle.
- Reset mid-operation (any state, including PRESENT): outputs drop immediately and the pending coin is lost. This is acceptable because the FSM's own reset clears the sum too.

Decomposition:
- Package vm_coin_pkg holds:
  - coin code constants COIN_NONE..COIN_100, shared with coin_summer and coin_dispenser;
  - the sensor-bit-to-code mapping function;
  - the state encoding (IDLE, MEASURE, WAIT_RELEASE, PRESENT, REJECT, JAM, COOLDOWN).
- Sub-module coin_sense_sync: 6-bit two-flop synchroniser with async active-low reset to 0.

Test Plan:
1. 5c clean pulse: coin_sense=000010 for 30 cycles, then 0. Expect coin_code=010 and coin_valid=1 from edge N+2, coin_ready=1 completes the transfer, then busy stays high for 64 cycles.
2. Glitch: coin_sense=001000 for 8 cycles. Expect no coin_valid, reject_gate=0, reject_count=0, and a return to IDLE.
3. Double coin: coin_sense=011000 for 30 cycles. Expect reject_gate=1 until release, reject_count=1, no coin_valid.
4. Disabled intake: accept_enable=0 and a 100c pulse of 30 cycles. Expect reject_gate=1 and reject_count=1. Then accept_enable=1 with the same pulse gives coin_code=110.
5. Backpressure plus jam:
   - 25c pulse with coin_ready low for 10 cycles: coin_valid=1 and coin_code=100 held stable throughout.
   - Next, 1c held 5000 cycles: jam_error=1 after about 4096 cycles; it clears after release and COOLDOWN.
6. Reset mid-PRESENT: drive reset=0 asynchronously. coin_valid, coin_code, busy and reject_count all go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/vm_coin_pkg.sv
// vm_coin_pkg: coin code constants, sensor-line to coin-code mapping and the
// coin acceptor state encoding. The coin codes are shared with coin_summer and
// coin_dispenser.
package vm_coin_pkg;

   localparam logic [2:0] COIN_NONE = 3'b000;
   localparam logic [2:0] COIN_1    = 3'b001;
   localparam logic [2:0] COIN_5    = 3'b010;
   localparam logic [2:0] COIN_10   = 3'b011;
   localparam logic [2:0] COIN_25   = 3'b100;
   localparam logic [2:0] COIN_50   = 3'b101;
   localparam logic [2:0] COIN_100  = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MEASURE,
      ST_WAIT_RELEASE,
      ST_PRESENT,
      ST_REJECT,
      ST_JAM,
      ST_COOLDOWN
   } coin_state_t;

   // One-hot sensor pattern to coin code; anything else maps to COIN_NONE.
   function automatic logic [2:0] sense_to_code(input logic [5:0] s);
      logic [2:0] code;
      case (s)
         6'b000001: code = COIN_1;
         6'b000010: code = COIN_5;
         6'b000100: code = COIN_10;
         6'b001000: code = COIN_25;
         6'b010000: code = COIN_50;
         6'b100000: code = COIN_100;
         default:   code = COIN_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/coin_sense_sync.sv
// coin_sense_sync: two-flop synchroniser for the six raw coin sensor lines.
// Ports: clock, reset (async active-low, clears to 0), coin_sense (raw),
// sense_s (synchronised).
module coin_sense_sync (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] coin_sense,
   output logic [5:0] sense_s
);

   logic [5:0] meta;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         meta    <= '0;
         sense_s <= '0;
      end else begin
         meta    <= coin_sense;
         sense_s <= meta;
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: synchronises, debounces and validates coin sensor pulses and
// presents one coin code per accepted coin on a valid/ready handshake.
// Ports: clock, reset (async active-low), accept_enable, coin_sense[5:0] (raw),
// coin_ready; outputs coin_code[2:0], coin_valid, reject_gate, jam_error,
// busy, reject_count[7:0]. All outputs are registered.
module coin_acceptor
   import vm_coin_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = 16,
   parameter int MAX_PULSE_CYCLES = 4096,
   parameter int COOLDOWN_CYCLES  = 64,
   parameter int CNT_W            = 13
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       accept_enable,
   input  logic [5:0] coin_sense,
   input  logic       coin_ready,
   output logic [2:0] coin_code,
   output logic       coin_valid,
   output logic       reject_gate,
   output logic       jam_error,
   output logic       busy,
   output logic [7:0] reject_count
);

   logic [5:0]  sense_s;
   coin_state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [5:0]  latched, latched_nx;
   logic        rej_inc;
   logic        one_hot;

   coin_sense_sync u_sync (
      .clock      (clock),
      .reset      (reset),
      .coin_sense (coin_sense),
      .sense_s    (sense_s)
   );

   assign one_hot = (sense_s != '0) && ((sense_s & (sense_s - 6'd1)) == '0);

   // The IDLE sample counts as the first stable cycle, so cnt starts at 1.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      latched_nx = latched;
      rej_inc    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (sense_s != '0) begin
               cnt_nx = CNT_W'(1);
               if (!one_hot || !accept_enable) begin
                  state_nx = ST_REJECT;
                  rej_inc  = 1'b1;
               end else begin
                  latched_nx = sense_s;
                  state_nx   = ST_MEASURE;
               end
            end
         end
         ST_MEASURE: begin
            if (sense_s == latched) begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt_nx == CNT_W'(DEBOUNCE_CYCLES)) state_nx = ST_WAIT_RELEASE;
            end else if (sense_s == '0) begin
               cnt_nx   = '0;
               state_nx = ST_IDLE;
            end else begin
               cnt_nx   = cnt + CNT_W'(1);
               state_nx = ST_REJECT;
               rej_inc  = 1'b1;
            end
         end
         ST_WAIT_RELEASE: begin
            if (sense_s == '0) begin
               state_nx = ST_PRESENT;
            end else if (sense_s != latched) begin
               cnt_nx   = cnt + CNT_W'(1);
               state_nx = ST_REJECT;
               rej_inc  = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt_nx == CNT_W'(MAX_PULSE_CYCLES)) state_nx = ST_JAM;
            end
         end
         ST_PRESENT: begin
            if (coin_ready) begin
               cnt_nx   = '0;
               state_nx = ST_COOLDOWN;
            end
         end
         ST_REJECT: begin
            if (sense_s == '0) begin
               cnt_nx   = '0;
               state_nx = ST_COOLDOWN;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt_nx >= CNT_W'(MAX_PULSE_CYCLES)) state_nx = ST_JAM;
            end
         end
         ST_JAM: begin
            if (sense_s == '0) begin
               cnt_nx   = '0;
               state_nx = ST_COOLDOWN;
            end
         end
         ST_COOLDOWN: begin
            cnt_nx = cnt + CNT_W'(1);
            if (cnt_nx == CNT_W'(COOLDOWN_CYCLES)) begin
               cnt_nx   = '0;
               state_nx = ST_IDLE;
            end
         end
         default: begin
            cnt_nx   = '0;
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         latched      <= '0;
         coin_code    <= COIN_NONE;
         coin_valid   <= 1'b0;
         reject_gate  <= 1'b0;
         jam_error    <= 1'b0;
         busy         <= 1'b0;
         reject_count <= '0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         latched     <= latched_nx;
         coin_valid  <= (state_nx == ST_PRESENT);
         coin_code   <= (state_nx == ST_PRESENT) ? sense_to_code(latched_nx) : COIN_NONE;
         reject_gate <= (state_nx == ST_REJECT) || (state_nx == ST_JAM);
         jam_error   <= (state_nx == ST_JAM);
         busy        <= (state_nx != ST_IDLE);
         if (rej_inc && (reject_count != '1)) reject_count <= reject_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed self-checking bench for coin_acceptor.
module tb_coin_acceptor;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       accept_enable = 1'b1;
   logic [5:0] coin_sense = '0;
   logic       coin_ready = 1'b0;
   logic [2:0] coin_code;
   logic       coin_valid;
   logic       reject_gate;
   logic       jam_error;
   logic       busy;
   logic [7:0] reject_count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   coin_acceptor #(
      .DEBOUNCE_CYCLES  (16),
      .MAX_PULSE_CYCLES (4096),
      .COOLDOWN_CYCLES  (64),
      .CNT_W            (13)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .accept_enable (accept_enable),
      .coin_sense    (coin_sense),
      .coin_ready    (coin_ready),
      .coin_code     (coin_code),
      .coin_valid    (coin_valid),
      .reject_gate   (reject_gate),
      .jam_error     (jam_error),
      .busy          (busy),
      .reject_count  (reject_count)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(3);
      total++;
      if ({coin_code, coin_valid, reject_gate, jam_error, busy, reject_count} !== 15'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {coin_code, coin_valid, reject_gate, jam_error, busy, reject_count});
      end
      reset = 1'b1;
      tick(1);
   endtask

   task automatic test_clean_5c();
      coin_sense = 6'b000010;
      tick(30);
      total++;
      if (busy !== 1'b1 || coin_valid !== 1'b0) begin
         bad++; $display("FAIL t1_hold busy=%b valid=%b want busy=1 valid=0", busy, coin_valid);
      end
      coin_sense = '0;
      @(posedge clock); @(posedge clock); @(negedge clock);
      total++;
      if (coin_valid !== 1'b0) begin
         bad++; $display("FAIL t1_valid_early got=%b want=0", coin_valid);
      end
      @(posedge clock); @(negedge clock);
      total++;
      if (coin_valid !== 1'b1 || coin_code !== 3'b010) begin
         bad++; $display("FAIL t1_present valid=%b code=%b want 1/010", coin_valid, coin_code);
      end
      coin_ready = 1'b1;
      tick(1);
      coin_ready = 1'b0;
      total++;
      if (coin_valid !== 1'b0 || busy !== 1'b1 || coin_code !== 3'b000) begin
         bad++; $display("FAIL t1_handshake valid=%b busy=%b code=%b want 0/1/000", coin_valid, busy, coin_code);
      end
      for (int i = 0; i < 63; i++) begin
         tick(1);
         total++;
         if (busy !== 1'b1) begin
            bad++; $display("FAIL t1_cooldown_busy cycle=%0d got=%b want=1", i, busy);
         end
      end
      tick(1);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL t1_cooldown_end got=%b want=0", busy);
      end
   endtask

   task automatic test_glitch();
      logic seen_valid = 1'b0;
      logic seen_rej   = 1'b0;
      coin_sense = 6'b001000;
      for (int i = 0; i < 28; i++) begin
         if (i == 8) coin_sense = '0;
         tick(1);
         if (coin_valid) seen_valid = 1'b1;
         if (reject_gate) seen_rej = 1'b1;
      end
      total++;
      if (seen_valid !== 1'b0 || seen_rej !== 1'b0 || reject_count !== 8'd0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL t2_glitch valid_seen=%b rej_seen=%b count=%0d busy=%b want 0/0/0/0",
                  seen_valid, seen_rej, reject_count, busy);
      end
   endtask

   task automatic test_double_coin();
      logic seen_valid = 1'b0;
      do_reset();
      coin_sense = 6'b011000;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (coin_valid) seen_valid = 1'b1;
      end
      total++;
      if (reject_gate !== 1'b1 || reject_count !== 8'd1) begin
         bad++; $display("FAIL t3_reject gate=%b count=%0d want 1/1", reject_gate, reject_count);
      end
      coin_sense = '0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (coin_valid) seen_valid = 1'b1;
      end
      total++;
      if (reject_gate !== 1'b0 || reject_count !== 8'd1 || seen_valid !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL t3_release gate=%b count=%0d valid_seen=%b busy=%b want 0/1/0/1",
                  reject_gate, reject_count, seen_valid, busy);
      end
      tick(70);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL t3_idle busy=%b want=0", busy);
      end
   endtask

   task automatic test_disabled_intake();
      do_reset();
      accept_enable = 1'b0;
      coin_sense = 6'b100000;
      tick(30);
      total++;
      if (reject_gate !== 1'b1 || reject_count !== 8'd1) begin
         bad++; $display("FAIL t4_disabled gate=%b count=%0d want 1/1", reject_gate, reject_count);
      end
      coin_sense = '0;
      tick(72);
      accept_enable = 1'b1;
      coin_sense = 6'b100000;
      tick(30);
      coin_sense = '0;
      tick(3);
      total++;
      if (coin_valid !== 1'b1 || coin_code !== 3'b110 || reject_count !== 8'd1) begin
         bad++; $display("FAIL t4_enabled valid=%b code=%b count=%0d want 1/110/1", coin_valid, coin_code, reject_count);
      end
      coin_ready = 1'b1;
      tick(1);
      coin_ready = 1'b0;
      tick(70);
   endtask

   task automatic test_backpressure_jam();
      int wait_cnt = 0;
      coin_sense = 6'b001000;
      tick(30);
      coin_sense = '0;
      while (coin_valid !== 1'b1 && wait_cnt < 10) begin
         tick(1);
         wait_cnt++;
      end
      total++;
      if (coin_valid !== 1'b1) begin
         bad++; $display("FAIL t5_valid_timeout got=%b want=1", coin_valid);
      end
      for (int i = 0; i < 10; i++) begin
         tick(1);
         total++;
         if (coin_valid !== 1'b1 || coin_code !== 3'b100) begin
            bad++; $display("FAIL t5_hold cycle=%0d valid=%b code=%b want 1/100", i, coin_valid, coin_code);
         end
      end
      coin_ready = 1'b1;
      tick(1);
      coin_ready = 1'b0;
      total++;
      if (coin_valid !== 1'b0) begin
         bad++; $display("FAIL t5_handshake valid=%b want=0", coin_valid);
      end
      tick(70);
      coin_sense = 6'b000001;
      tick(4050);
      total++;
      if (jam_error !== 1'b0) begin
         bad++; $display("FAIL t5_jam_early jam=%b want=0", jam_error);
      end
      tick(100);
      total++;
      if (jam_error !== 1'b1 || reject_gate !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL t5_jam jam=%b gate=%b busy=%b want 1/1/1", jam_error, reject_gate, busy);
      end
      tick(850);
      coin_sense = '0;
      tick(5);
      total++;
      if (jam_error !== 1'b0 || reject_gate !== 1'b0 || busy !== 1'b1) begin
         bad++; $display("FAIL t5_jam_clear jam=%b gate=%b busy=%b want 0/0/1", jam_error, reject_gate, busy);
      end
      tick(70);
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL t5_idle busy=%b want=0", busy);
      end
   endtask

   task automatic test_reset_mid_present();
      do_reset();
      coin_sense = 6'b000011;
      tick(20);
      coin_sense = '0;
      tick(72);
      coin_sense = 6'b000100;
      tick(30);
      coin_sense = '0;
      tick(4);
      total++;
      if (coin_valid !== 1'b1 || coin_code !== 3'b011 || reject_count !== 8'd1) begin
         bad++; $display("FAIL t6_pre valid=%b code=%b count=%0d want 1/011/1", coin_valid, coin_code, reject_count);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (coin_valid !== 1'b0 || coin_code !== 3'b000 || busy !== 1'b0 || reject_count !== 8'd0) begin
         bad++;
         $display("FAIL t6_async valid=%b code=%b busy=%b count=%0d want 0/000/0/0",
                  coin_valid, coin_code, busy, reject_count);
      end
      tick(2);
      reset = 1'b1;
      tick(3);
      total++;
      if (coin_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL t6_after valid=%b busy=%b want 0/0", coin_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_clean_5c();
      test_glitch();
      test_double_coin();
      test_disabled_intake();
      test_backpressure_jam();
      test_reset_mid_present();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
